// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch/sequencer: instruction class
// encodings, per-class hold lengths, FSM states and the length lookup.
package fetch_pkg;

  localparam int DEF_INSTR_WIDTH = 20;
  localparam int DEF_PC_BITS     = 5;
  localparam int DEF_PROG_DEPTH  = 32;

  localparam logic [1:0] CLS_HALT  = 2'b00;
  localparam logic [1:0] CLS_STD   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  localparam logic [2:0] LEN_STD   = 3'd3;
  localparam logic [2:0] LEN_LOAD  = 3'd4;
  localparam logic [2:0] LEN_STORE = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_EXEC,
    S_HALT
  } state_t;

  // Cycles the control unit needs per class; halt never gets executed, so
  // its entry only keeps the hold-counter math from underflowing.
  function automatic logic [2:0] len_of(input logic [1:0] cls);
    case (cls)
      CLS_STD:   len_of = LEN_STD;
      CLS_LOAD:  len_of = LEN_LOAD;
      CLS_STORE: len_of = LEN_STORE;
      default:   len_of = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/fetch_imem.sv
// Program memory: one synchronous write port, one combinational read port.
// The array has no reset so a loaded program survives rst.
module fetch_imem #(
  parameter int WIDTH = 20,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/sequencer for the control unit. Holds each instruction
// word on instr for exactly the cycles its class needs, then advances.
// Stops on a halt-class word or at the end of memory; only rst leaves HALT.
// Optional: define RETIRE_CNT_EN to add an 8-bit retired-instruction counter.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int PC_BITS     = DEF_PC_BITS,
  parameter int PROG_DEPTH  = DEF_PROG_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [PC_BITS-1:0]     load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   run,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   halted
`ifdef RETIRE_CNT_EN
  ,
  output logic [7:0]             retired
`endif
);

  state_t                 r_state;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [PC_BITS-1:0]     r_pc;
  logic [2:0]             r_cnt;
  logic                   r_busy;
  logic                   r_halted;

  logic                   w_we;
  logic [PC_BITS-1:0]     w_raddr;
  logic [INSTR_WIDTH-1:0] w_rdata;
  logic [INSTR_WIDTH-1:0] w_word0;
  logic [1:0]             w_word0_cls;
  logic [1:0]             w_nxt_cls;
  logic [1:0]             w_cur_cls;
  logic                   w_last;

  // Programming is only accepted while idle; a running program is immutable.
  assign w_we = load_en && (r_state == S_IDLE);

  // Single read port: word 0 when starting, otherwise the next word.
  assign w_raddr = (r_state == S_IDLE) ? '0 : r_pc + PC_BITS'(1);

  fetch_imem #(
    .WIDTH(INSTR_WIDTH),
    .AW   (PC_BITS),
    .DEPTH(PROG_DEPTH)
  ) u_imem (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(load_addr),
    .i_wdata(load_data),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );

  // A word written to address 0 in the same cycle as run is used directly.
  assign w_word0     = (load_en && load_addr == '0) ? load_data : w_rdata;
  assign w_word0_cls = w_word0[INSTR_WIDTH-1 -: 2];
  assign w_nxt_cls   = w_rdata[INSTR_WIDTH-1 -: 2];
  assign w_cur_cls   = r_instr[INSTR_WIDTH-1 -: 2];
  assign w_last      = (r_pc == PC_BITS'(PROG_DEPTH - 1));

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_instr  <= '0;
      r_pc     <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_pc <= '0;
            if (w_word0_cls == CLS_HALT) begin
              r_instr  <= '0;
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else begin
              r_instr <= w_word0;
              r_busy  <= 1'b1;
              r_state <= S_LAUNCH;
            end
          end
        end
        // One extra cycle for the control unit to leave its reset state.
        S_LAUNCH: begin
          r_cnt   <= len_of(w_cur_cls) - 3'd1;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else if (w_last) begin
            r_instr  <= '0;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if (w_nxt_cls == CLS_HALT) begin
            r_pc     <= r_pc + PC_BITS'(1);
            r_instr  <= '0;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_pc    <= r_pc + PC_BITS'(1);
            r_instr <= w_rdata;
            r_cnt   <= len_of(w_nxt_cls) - 3'd1;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr  = r_instr;
  assign pc     = r_pc;
  assign busy   = r_busy;
  assign halted = r_halted;

`ifdef RETIRE_CNT_EN
  logic [7:0] r_retired;

  // One count per instruction whose hold period completes; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= '0;
    end else if (r_state == S_EXEC && r_cnt == 3'd0) begin
      r_retired <= r_retired + 8'd1;
    end
  end

  assign retired = r_retired;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [4:0]  load_addr = '0;
  logic [19:0] load_data = '0;
  logic        run = 1'b0;
  logic [19:0] instr;
  logic [4:0]  pc;
  logic        busy;
  logic        halted;
`ifdef RETIRE_CNT_EN
  logic [7:0]  retired;
`endif

  instr_fetch dut (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .run      (run),
    .instr    (instr),
    .pc       (pc),
    .busy     (busy),
    .halted   (halted)
`ifdef RETIRE_CNT_EN
    ,
    .retired  (retired)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] instr;
    logic [4:0]  pc;
    logic        busy;
    logic        halted;
    logic [7:0]  ret;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_trace[$];
  exp_t        m_halt;
  logic [19:0] m_mem [32];
  logic [19:0] prog  [32];
  int          m_mode = 0;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  function automatic int hold_len(input logic [1:0] c);
    case (c)
      2'b01:   return 3;
      2'b10:   return 4;
      2'b11:   return 3;
      default: return 0;
    endcase
  endfunction

  task automatic build_trace();
    exp_t        e;
    logic [19:0] w;
    logic [7:0]  r;
    bit          done;
    int          n;
    m_trace.delete();
    r    = 8'd0;
    done = 0;
    for (int k = 0; k < 32 && !done; k++) begin
      w = m_mem[k];
      if (w[19:18] == 2'b00) begin
        e = '0; e.pc = 5'(k); e.halted = 1'b1; e.ret = r;
        m_trace.push_back(e);
        done = 1;
      end else begin
        n = hold_len(w[19:18]) + ((k == 0) ? 1 : 0);
        e = '0; e.instr = w; e.pc = 5'(k); e.busy = 1'b1; e.ret = r;
        for (int j = 0; j < n; j++) m_trace.push_back(e);
        r = r + 8'd1;
        if (k == 31) begin
          e = '0; e.pc = 5'd31; e.halted = 1'b1; e.ret = r;
          m_trace.push_back(e);
          done = 1;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic le, input logic [4:0] a,
                      input logic [19:0] d, input logic rn);
    exp_t e;
    rst = r; load_en = le; load_addr = a; load_data = d; run = rn;
    e = '0;
    if (r) begin
      m_mode = 0;
      m_trace.delete();
    end else begin
      case (m_mode)
        0: begin
          if (le) m_mem[a] = d;
          if (rn) begin
            build_trace();
            m_mode = 1;
          end
        end
        default: ;
      endcase
      if (m_mode == 1) begin
        e = m_trace.pop_front();
        if (m_trace.size() == 0) begin
          m_mode = 2;
          m_halt = e;
        end
      end else if (m_mode == 2) begin
        e = m_halt;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 20'd0, 1'b0);
  endtask

  task automatic reset1();
    step(1'b1, 1'b0, 5'd0, 20'd0, 1'b0);
  endtask

  task automatic load_all();
    for (int k = 0; k < 32; k++) step(1'b0, 1'b1, 5'(k), prog[k], 1'b0);
  endtask

  task automatic go();
    step(1'b0, 1'b0, 5'd0, 20'd0, 1'b1);
  endtask

  function automatic logic [19:0] rand_word();
    logic [1:0] c;
    c = ($urandom_range(0, 11) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
    return {c, 18'($urandom)};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    cyc++;
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      ok = (instr === e.instr) && (pc === e.pc) && (busy === e.busy) &&
           (halted === e.halted);
`ifdef RETIRE_CNT_EN
      ok = ok && (retired === e.ret);
`endif
      checks++;
      if (!ok) begin
        errors++;
`ifdef RETIRE_CNT_EN
        $display("FAIL outputs cyc=%0d got instr=%h pc=%0d busy=%b halted=%b retired=%0d exp instr=%h pc=%0d busy=%b halted=%b retired=%0d",
                 cyc, instr, pc, busy, halted, retired, e.instr, e.pc, e.busy, e.halted, e.ret);
`else
        $display("FAIL outputs cyc=%0d got instr=%h pc=%0d busy=%b halted=%b exp instr=%h pc=%0d busy=%b halted=%b",
                 cyc, instr, pc, busy, halted, e.instr, e.pc, e.busy, e.halted);
`endif
      end
    end
  end

  initial begin
    for (int k = 0; k < 32; k++) m_mem[k] = 20'd0;
    reset1();
    reset1();
    idle(2);

    for (int k = 0; k < 32; k++) prog[k] = rand_word();
    prog[0] = 20'h5A0F1; prog[1] = 20'h00000;
    load_all();
    go();
    idle(8);
    checks++;
    if (halted !== 1'b1 || pc !== 5'd1 || instr !== 20'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single: halted=%b pc=%0d instr=%h busy=%b", halted, pc, instr, busy);
    end
    step(1'b0, 1'b0, 5'd0, 20'd0, 1'b1);
    step(1'b0, 1'b1, 5'd1, 20'h90010, 1'b0);
    reset1();

    prog[0] = 20'h5A0F1; prog[1] = 20'h90010; prog[2] = 20'hC4020; prog[3] = 20'h0;
    load_all();
    go();
    idle(15);
    checks++;
    if (halted !== 1'b1 || pc !== 5'd3) begin
      errors++;
      $display("FAIL mixed: halted=%b pc=%0d", halted, pc);
    end
    reset1();

    prog[0] = 20'h0;
    step(1'b0, 1'b1, 5'd0, 20'h0, 1'b0);
    go();
    idle(4);
    checks++;
    if (halted !== 1'b1 || pc !== 5'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty: halted=%b pc=%0d busy=%b", halted, pc, busy);
    end
    reset1();

    for (int k = 0; k < 32; k++) prog[k] = 20'h5A0F1;
    load_all();
    go();
    idle(102);
    checks++;
    if (halted !== 1'b1 || pc !== 5'd31) begin
      errors++;
      $display("FAIL eom: halted=%b pc=%0d", halted, pc);
    end
    reset1();

    step(1'b0, 1'b1, 5'd1, 20'h0, 1'b0);
    step(1'b0, 1'b1, 5'd0, 20'h90010, 1'b1);
    checks++;
    if (instr !== 20'h90010 || busy !== 1'b1) begin
      errors++;
      $display("FAIL write-through: instr=%h busy=%b", instr, busy);
    end
    idle(8);
    reset1();

    prog[0] = 20'h5A0F1; prog[1] = 20'h90010; prog[2] = 20'hC4020; prog[3] = 20'h0;
    load_all();
    go();
    idle(2);
    step(1'b0, 1'b1, 5'd1, 20'h00000, 1'b0);
    step(1'b0, 1'b1, 5'd1, 20'h4BEEF, 1'b1);
    idle(1);
    reset1();
    idle(2);
    go();
    idle(15);
    reset1();

    for (int it = 0; it < 15; it++) begin
      for (int k = 0; k < 32; k++) prog[k] = rand_word();
      if (it % 3 == 0) prog[0] = {2'($urandom_range(1, 3)), 18'($urandom)};
      load_all();
      go();
      for (int c = 0; c < 140; c++) begin
        logic r;
        logic le;
        r  = ($urandom_range(0, 199) == 0);
        le = r ? 1'b0 : 1'($urandom_range(0, 3) == 0);
        step(r, le, 5'($urandom), rand_word(),
             1'($urandom_range(0, 7) == 0));
      end
      reset1();
    end

    idle(1);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
